// File: rtl/axi_addr.sv
// AXI beat address generator: next address for FIXED/INCR/WRAP bursts, plus a
// registered copy and a registered illegal-burst flag.
module axi_addr #(
  parameter logic ALIGN_ADDR = 1'b1,
  parameter int   ADDR_WIDTH = 12,
  parameter int   DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [ADDR_WIDTH-1:0] next_addr_q,
  output logic                  err_q
);

  // Internal width covers a 2048-byte wrap window above the top of the address space.
  localparam int CW       = ((ADDR_WIDTH > 12) ? ADDR_WIDTH : 12) + 1;
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  logic [CW-1:0]         addr_w;
  logic [CW-1:0]         nb;
  logic [CW-1:0]         addr_aligned;
  logic [CW-1:0]         aligned_next;
  logic [CW-1:0]         incr_base;
  logic [CW-1:0]         wrap_total;
  logic [CW-1:0]         wrap_lo;
  logic [CW-1:0]         wrap_hi;
  logic [2:0]            len_lg;
  logic [3:0]            wrap_lg;
  logic                  wrap_len_ok;
  logic [ADDR_WIDTH-1:0] next_addr_d;
  logic                  err_d;

  always_comb begin
    addr_w       = CW'(addr);
    nb           = CW'(1) << size;
    addr_aligned = addr_w & ~(nb - CW'(1));
    aligned_next = addr_aligned + nb;
    incr_base    = ALIGN_ADDR ? addr_aligned : addr_w;

    len_lg      = 3'd0;
    wrap_len_ok = 1'b1;
    case (len)
      8'd1:    len_lg = 3'd1;
      8'd3:    len_lg = 3'd2;
      8'd7:    len_lg = 3'd3;
      8'd15:   len_lg = 3'd4;
      default: wrap_len_ok = 1'b0;
    endcase

    wrap_lg    = {1'b0, size} + {1'b0, len_lg};
    wrap_total = CW'(1) << wrap_lg;
    wrap_lo    = addr_w & ~(wrap_total - CW'(1));
    wrap_hi    = wrap_lo + wrap_total;

    next_addr_d = addr;
    case (burst)
      BURST_FIXED: next_addr_d = addr;
      BURST_INCR:  next_addr_d = ADDR_WIDTH'(incr_base + nb);
      BURST_WRAP: begin
        // An illegal wrap length degrades to a plain aligned increment.
        if (!wrap_len_ok || (aligned_next < wrap_hi))
          next_addr_d = ADDR_WIDTH'(aligned_next);
        else
          next_addr_d = ADDR_WIDTH'(wrap_lo);
      end
      default:     next_addr_d = addr;
    endcase

    err_d = (burst == BURST_RSVD) ||
            ((burst == BURST_WRAP) && !wrap_len_ok) ||
            (int'(size) > MAX_SIZE);
  end

  assign next_addr = next_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_addr.sv
// Scoreboard bench for axi_addr (DATA_WIDTH=64, ALIGN_ADDR=1, ADDR_WIDTH=12).
module tb_axi_addr;

  typedef struct packed {
    logic [11:0] na;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr = '0;
  logic [1:0]  burst = '0;
  logic [2:0]  size = '0;
  logic [7:0]  len = '0;
  logic [11:0] next_addr;
  logic [11:0] next_addr_q;
  logic        err_q;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  axi_addr #(
    .ALIGN_ADDR (1'b1),
    .ADDR_WIDTH (12),
    .DATA_WIDTH (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .burst       (burst),
    .size        (size),
    .len         (len),
    .next_addr   (next_addr),
    .next_addr_q (next_addr_q),
    .err_q       (err_q)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per driven vector, checked just after the edge that registers it.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if (next_addr !== e.na) begin
        errors = errors + 1;
        $display("FAIL next_addr got %h want %h", next_addr, e.na);
      end
      checks = checks + 1;
      if (next_addr_q !== e.na) begin
        errors = errors + 1;
        $display("FAIL next_addr_q got %h want %h", next_addr_q, e.na);
      end
      checks = checks + 1;
      if (err_q !== e.err) begin
        errors = errors + 1;
        $display("FAIL err_q got %b want %b (addr %h burst %b size %0d len %0d)",
                 err_q, e.err, addr, burst, size, len);
      end
    end
  end

  task automatic drive(input logic [11:0] a, input logic [1:0] b, input logic [2:0] s,
                       input logic [7:0] l, input logic [11:0] exp_na, input logic exp_err);
    exp_t e;
    @(negedge clk);
    addr  = a;
    burst = b;
    size  = s;
    len   = l;
    e.na  = exp_na;
    e.err = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [11:0] got, input logic [11:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check_val("reset next_addr_q", next_addr_q, 12'h000);
    check_val("reset err_q", {11'd0, err_q}, 12'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // FIXED held two cycles
    drive(12'h000, 2'b00, 3'd2, 8'd2, 12'h000, 1'b0);
    drive(12'h000, 2'b00, 3'd2, 8'd2, 12'h000, 1'b0);
    // INCR from 0
    drive(12'h000, 2'b01, 3'd2, 8'd3, 12'h004, 1'b0);
    drive(12'h004, 2'b01, 3'd2, 8'd3, 12'h008, 1'b0);
    drive(12'h008, 2'b01, 3'd2, 8'd3, 12'h00C, 1'b0);
    drive(12'h00C, 2'b01, 3'd2, 8'd3, 12'h010, 1'b0);
    // INCR from unaligned 0x7
    drive(12'h007, 2'b01, 3'd2, 8'd3, 12'h008, 1'b0);
    drive(12'h008, 2'b01, 3'd2, 8'd3, 12'h00C, 1'b0);
    drive(12'h00C, 2'b01, 3'd2, 8'd3, 12'h010, 1'b0);
    drive(12'h010, 2'b01, 3'd2, 8'd3, 12'h014, 1'b0);
    drive(12'h014, 2'b01, 3'd2, 8'd4, 12'h018, 1'b0);
    drive(12'h001, 2'b01, 3'd2, 8'd0, 12'h004, 1'b0);
    // WRAP size 2 len 3 (16-byte window)
    drive(12'h004, 2'b10, 3'd2, 8'd3, 12'h008, 1'b0);
    drive(12'h008, 2'b10, 3'd2, 8'd3, 12'h00C, 1'b0);
    drive(12'h00C, 2'b10, 3'd2, 8'd3, 12'h000, 1'b0);
    drive(12'h000, 2'b10, 3'd2, 8'd3, 12'h004, 1'b0);
    drive(12'h00D, 2'b10, 3'd2, 8'd3, 12'h000, 1'b0);
    drive(12'h018, 2'b10, 3'd3, 8'd1, 12'h010, 1'b0);
    drive(12'h128, 2'b10, 3'd3, 8'd7, 12'h130, 1'b0);
    // Illegal bursts, each followed by a legal one (flag is not sticky)
    drive(12'h010, 2'b11, 3'd2, 8'd0, 12'h010, 1'b1);
    drive(12'h010, 2'b00, 3'd3, 8'd0, 12'h010, 1'b0);
    drive(12'h004, 2'b10, 3'd2, 8'd2, 12'h008, 1'b1);
    drive(12'h000, 2'b01, 3'd4, 8'd0, 12'h010, 1'b1);
    drive(12'h100, 2'b01, 3'd7, 8'd0, 12'h180, 1'b1);
    drive(12'hF80, 2'b10, 3'd7, 8'd15, 12'h800, 1'b1);
    drive(12'h020, 2'b01, 3'd3, 8'd0, 12'h028, 1'b0);
    // Mid-stream reset right after an illegal burst was registered
    drive(12'h010, 2'b11, 3'd1, 8'd0, 12'h010, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("midreset next_addr_q", next_addr_q, 12'h000);
    check_val("midreset err_q", {11'd0, err_q}, 12'h000);
    check_val("midreset next_addr", next_addr, 12'h010);
    @(negedge clk);
    rst = 1'b0;
    // Address space wrap-around
    drive(12'hFFC, 2'b01, 3'd2, 8'd0, 12'h000, 1'b0);
    drive(12'hFFF, 2'b01, 3'd0, 8'd0, 12'h000, 1'b0);
    drive(12'h3F0, 2'b10, 3'd1, 8'd1, 12'h3F2, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check_val("scoreboard drained", 12'(exp_q.size()), 12'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_addr.md
AXI_ADDR -- requirements
Module: axi_addr

Interface
REQ-001 Parameter ALIGN_ADDR, default 1'b1: 1 = INCR next address computed from the size-aligned current address; 0 = computed from the unaligned address.
REQ-002 Parameter ADDR_WIDTH, default 12: address width in bits.
REQ-003 Parameter DATA_WIDTH, default 32: data bus width in bits, a power of two from 8 to 1024; the bench runs 64.
REQ-004 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 addr  input  ADDR_WIDTH  current beat address.
REQ-007 burst  input  2  AXI burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-008 size  input  3  AXI size; beat bytes NB = 2^size.
REQ-009 len  input  8  AXI length; beats = len+1.
REQ-010 next_addr  output  ADDR_WIDTH  combinational address of the following beat.
REQ-011 next_addr_q  output  ADDR_WIDTH  next_addr registered on clk.
REQ-012 err_q  output  1  registered illegal-burst flag.

Function
REQ-013 next_addr SHALL be purely combinational from addr/burst/size/len, with zero clock latency and no dependence on clk or rst.
REQ-014 Aligned address A = addr with its low size bits cleared.
REQ-015 FIXED: next_addr SHALL equal addr, whatever the size and len.
REQ-016 INCR, ALIGN_ADDR=1: next_addr SHALL equal A + NB; e.g. addr 0x7, size 2 -> 0x8; addr 0x1, size 2 -> 0x4.
REQ-017 INCR, ALIGN_ADDR=0: next_addr SHALL equal addr + NB.
REQ-018 INCR arithmetic SHALL be modulo 2^ADDR_WIDTH; carry out is discarded and no 4KB-boundary handling is applied.
REQ-019 WRAP: total T = NB*(len+1) and lower boundary W = addr with its low log2(T) bits cleared.
REQ-020 WRAP: next_addr SHALL be A + NB if A + NB < W + T, otherwise W; alignment is applied regardless of ALIGN_ADDR.
REQ-021 WRAP with len not in {1,3,7,15}: next_addr SHALL equal A + NB (INCR behaviour), and the burst is illegal.
REQ-022 Reserved burst 11: next_addr SHALL equal addr, and the burst is illegal.
REQ-023 Illegal condition, any of: burst==11; WRAP with len not in {1,3,7,15}; size > log2(DATA_WIDTH/8).
REQ-024 An oversize size SHALL still be used as given for next_addr arithmetic; it is only flagged.
REQ-025 Each rising clk edge: next_addr_q <= next_addr, and err_q <= illegal condition of the current inputs (not sticky).
REQ-026 Shifts and masks SHALL be sized so that size up to 7 and T up to 2048 never overflow intermediates beyond ADDR_WIDTH truncation of the result.

Reset
REQ-027 While rst is high, next_addr_q SHALL be 0 and err_q SHALL be 0, immediately, without waiting for a clock edge.
REQ-028 next_addr SHALL be unaffected by rst.
REQ-029 The first rising edge after rst deasserts SHALL load next_addr_q and err_q normally.

Verification (DATA_WIDTH=64, ALIGN_ADDR=1, ADDR_WIDTH=12)
REQ-030 FIXED, addr 0, size 2, len 2, held two cycles -> next_addr 0 each cycle; err_q 0.
REQ-031 INCR, size 2, len 3, start 0x0, each cycle feeding next_addr back to addr -> 0x4, 0x8, 0xC, 0x10.
REQ-032 INCR, size 2, start 0x7, fed back -> 0x8, 0xC, 0x10, 0x14 (len 3), continuing to 0x18 (len 4).
REQ-033 WRAP, size 2, len 3, start 0x4, fed back -> 0x8, 0xC, 0x0, 0x4.
REQ-034 Illegal bursts -> err_q 1 one cycle after each of: burst 11 with addr 0x10 (next_addr 0x10); WRAP with len 2; size 4.
REQ-035 Reset and wrap-around: rst asserted mid-stream -> next_addr_q and err_q read 0 at once; INCR from addr 0xFFC, size 2 -> next_addr 0x000.
